// File: rtl/udp_reg_ring_master_pkg.sv
// Shared definitions for the udp_reg ring master.
//  - Ring field widths (register word address, host data word).
//  - Error word returned on a timed-out command.
//  - FSM state encoding.
package udp_reg_ring_master_pkg;

  localparam int UDP_REG_ADDR_WIDTH  = 23;
  localparam int CPCI_NF2_DATA_WIDTH = 32;

  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] ERR_WORD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/udp_reg_ring_master_if.sv
// Host command/response bus plus udp_reg ring head and tail.
//  master modport : the ring master (drives cmd_ready, rsp_*, ring head; reads cmd_*, ring tail)
//  slave modport  : host + ring side (drives cmd_*, ring tail; reads the rest)
interface udp_reg_ring_master_if #(
  parameter int UDP_REG_SRC_WIDTH = 2
) ();
  import udp_reg_ring_master_pkg::*;

  // host command / response
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic                           cmd_rd_wr_L;
  logic [UDP_REG_ADDR_WIDTH-1:0]  cmd_addr;
  logic [CPCI_NF2_DATA_WIDTH-1:0] cmd_data;
  logic                           rsp_valid;
  logic [CPCI_NF2_DATA_WIDTH-1:0] rsp_data;
  logic                           rsp_err;
  logic                           rsp_timeout;

  // ring head (request leaves the master)
  logic                           reg_req_out;
  logic                           reg_ack_out;
  logic                           reg_rd_wr_L_out;
  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out;
  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out;
  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out;

  // ring tail (request comes back)
  logic                           reg_req_in;
  logic                           reg_ack_in;
  logic                           reg_rd_wr_L_in;
  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in;
  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in;
  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in;

  modport master (
    input  cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_data,
    input  reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
    output reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
  );

  modport slave (
    output cmd_valid, cmd_rd_wr_L, cmd_addr, cmd_data,
    output reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_timeout,
    input  reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out
  );

endinterface

// File: rtl/udp_reg_ring_master.sv
// udp_reg ring master: accepts one host command at a time, launches it as a single-cycle
// request at the ring head, waits for its own request to come back at the ring tail (or a
// timeout), then returns a one-cycle response to the host.
// Ports:
//  clk   - clock
//  reset - asynchronous, active-high reset
//  bus   - master modport: host cmd/rsp handshake plus ring head (out) and ring tail (in)
// All outputs are registered; output registers load the values belonging to the next state.
module udp_reg_ring_master #(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ID            = 0,
  parameter int TIMEOUT_CYCLES    = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  udp_reg_ring_master_if.master bus
);
  import udp_reg_ring_master_pkg::*;

  // bits needed to hold values 0 .. value-1
  function automatic int f_log2(input int value);
    longint unsigned span;
    int              bits;
    span = 64'd1;
    bits = 0;
    while (span < 64'(value)) begin
      span = span << 1;
      bits = bits + 1;
    end
    return bits;
  endfunction

  localparam int TO_WIDTH = f_log2(TIMEOUT_CYCLES + 1);
  // WAIT lasts exactly TIMEOUT_CYCLES cycles: counter runs 0 .. TIMEOUT_CYCLES-1
  localparam logic [TO_WIDTH-1:0]          TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_VAL = UDP_REG_SRC_WIDTH'(SRC_ID);

  state_t                         r_state;
  state_t                         w_next_state;
  logic [TO_WIDTH-1:0]            r_cnt;
  logic [UDP_REG_ADDR_WIDTH-1:0]  r_addr;

  logic                           w_accept;
  logic                           w_match;
  logic                           w_timeout;

  logic                           r_cmd_ready,   w_cmd_ready;
  logic                           r_rsp_valid,   w_rsp_valid;
  logic [CPCI_NF2_DATA_WIDTH-1:0] r_rsp_data,    w_rsp_data;
  logic                           r_rsp_err,     w_rsp_err;
  logic                           r_rsp_timeout, w_rsp_timeout;
  logic                           r_req_out,     w_req_out;
  logic                           r_rd_wr_L_out, w_rd_wr_L_out;
  logic [UDP_REG_ADDR_WIDTH-1:0]  r_addr_out,    w_addr_out;
  logic [CPCI_NF2_DATA_WIDTH-1:0] r_data_out,    w_data_out;
  logic [UDP_REG_SRC_WIDTH-1:0]   r_src_out,     w_src_out;

  // the returned rd/wr flag carries no information the master needs
  logic w_unused_rd_wr;
  assign w_unused_rd_wr = bus.reg_rd_wr_L_in;

  // r_cmd_ready is only high in IDLE, and stays low until the first clock after reset
  assign w_accept  = r_cmd_ready && bus.cmd_valid;
  // only our own request (src and address) terminates the wait; anything else is dropped
  assign w_match   = bus.reg_req_in && (bus.reg_src_in == SRC_VAL) && (bus.reg_addr_in == r_addr);
  assign w_timeout = (r_cnt == TO_LAST);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  w_next_state = w_accept ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT:  w_next_state = (w_match || w_timeout) ? ST_RESP : ST_WAIT;
      ST_RESP:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // output logic: values the output registers take on entering the next state
  always_comb begin
    w_cmd_ready   = (w_next_state == ST_IDLE);
    w_rsp_valid   = 1'b0;
    w_rsp_data    = '0;
    w_rsp_err     = 1'b0;
    w_rsp_timeout = 1'b0;
    w_req_out     = 1'b0;
    w_rd_wr_L_out = 1'b0;
    w_addr_out    = '0;
    w_data_out    = '0;
    w_src_out     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_req_out     = 1'b1;
          w_rd_wr_L_out = bus.cmd_rd_wr_L;
          w_addr_out    = bus.cmd_addr;
          w_data_out    = bus.cmd_rd_wr_L ? '0 : bus.cmd_data;
          w_src_out     = SRC_VAL;
        end else begin
          w_req_out     = 1'b0;
        end
      end
      ST_WAIT: begin
        // a return in the last WAIT cycle beats the timeout
        if (w_match) begin
          w_rsp_valid   = 1'b1;
          w_rsp_data    = bus.reg_data_in;
          w_rsp_err     = !bus.reg_ack_in;
          w_rsp_timeout = 1'b0;
        end else if (w_timeout) begin
          w_rsp_valid   = 1'b1;
          w_rsp_data    = ERR_WORD;
          w_rsp_err     = 1'b1;
          w_rsp_timeout = 1'b1;
        end else begin
          w_rsp_valid   = 1'b0;
        end
      end
      default: begin
        w_rsp_valid = 1'b0;
      end
    endcase
  end

  // output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_req_out     <= 1'b0;
      r_rd_wr_L_out <= 1'b0;
      r_addr_out    <= '0;
      r_data_out    <= '0;
      r_src_out     <= '0;
    end else begin
      r_cmd_ready   <= w_cmd_ready;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_data    <= w_rsp_data;
      r_rsp_err     <= w_rsp_err;
      r_rsp_timeout <= w_rsp_timeout;
      r_req_out     <= w_req_out;
      r_rd_wr_L_out <= w_rd_wr_L_out;
      r_addr_out    <= w_addr_out;
      r_data_out    <= w_data_out;
      r_src_out     <= w_src_out;
    end
  end

  // command address latch and WAIT cycle counter (cleared during ISSUE)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= bus.cmd_addr;
      end else begin
        r_addr <= r_addr;
      end
      if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + TO_WIDTH'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign bus.cmd_ready       = r_cmd_ready;
  assign bus.rsp_valid       = r_rsp_valid;
  assign bus.rsp_data        = r_rsp_data;
  assign bus.rsp_err         = r_rsp_err;
  assign bus.rsp_timeout     = r_rsp_timeout;
  assign bus.reg_req_out     = r_req_out;
  assign bus.reg_ack_out     = 1'b0;  // the master never pre-acks
  assign bus.reg_rd_wr_L_out = r_rd_wr_L_out;
  assign bus.reg_addr_out    = r_addr_out;
  assign bus.reg_data_out    = r_data_out;
  assign bus.reg_src_out     = r_src_out;

endmodule
